// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display readback path.
//   - SEG_W: width of the segment bus (segments a..g, index 0 = a).
//   - SEG_0 .. SEG_F: active-low segment patterns for hex digits 0..F.
//     These are the same patterns the hex-to-segment decoder drives.
//   - state_t: readback state machine encoding.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [0:SEG_W-1] seg_t;

    // Patterns are written abcdefg, 0 = lit.
    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001101;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// seg7_pattern_to_hex
// Combinational inverse of the hex-to-segment decoder.
// Ports:
//   seg    in  [0:6]  active-low segment pattern a..g
//   hit    out 1      pattern is one of the 16 hex codes
//   nibble out 4      decoded hex value (0 when hit = 0)
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [0:SEG_W-1] seg,
    output logic             hit,
    output logic [3:0]       nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader
// Readback receiver for the multiplexed 7-segment bus. Waits for each
// {DigSel, Seg} pair to settle, decodes it back to a hex nibble and
// assembles the nibbles into a frame handed to the consumer.
//
// state    | meaning
// IDLE     | bus blanked (DigSel all zero), waiting for activity
// SETTLE   | counting consecutive cycles the pair has held
// CAPTURE  | one cycle: decode the settled pair and write it
// HOLD     | pair captured, waiting for it to change
//
// Ports:
//   Clock         in   sole clock, rising edge
//   Reset         in   synchronous, active-high
//   Seg           in   [0:6] segments a..g, 0 = lit
//   DigSel        in   DIGITS one-hot digit select, all-zero = blanking
//   FrameAck      in   consumer accepts the pending frame
//   Valor         out  4*DIGITS captured nibbles, digit i at [4i+3:4i]
//   DigitoValido  out  DIGITS per-digit captured flags for current frame
//   FrameReady    out  complete frame pending until acked
//   Erro          out  sticky: settled pattern matched no hex code
//   Overrun       out  sticky: valid capture dropped while frame pending
//   ErrCount      out  8, saturating invalid-pattern count
//                      (present only with SEG7_READER_ERR_CNT_EN defined)
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [0:SEG_W-1]      Seg,
    input  logic [DIGITS-1:0]     DigSel,
    input  logic                  FrameAck,
    output logic [4*DIGITS-1:0]   Valor,
    output logic [DIGITS-1:0]     DigitoValido,
    output logic                  FrameReady,
    output logic                  Erro,
    output logic                  Overrun
`ifdef SEG7_READER_ERR_CNT_EN
    ,
    output logic [7:0]            ErrCount
`endif
);

    localparam int S_W   = DIGITS + SEG_W;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [S_W-1:0]      s_q;

    logic [S_W-1:0]      in_pair;
    logic [DIGITS-1:0]   s_digsel;
    logic [0:SEG_W-1]    s_seg;
    logic                pair_changed;
    logic                in_blank;
    logic                sel_onehot;
    logic                hit;
    logic [3:0]          nibble;
    logic                capture_en;
    logic                cap_valid;
    logic                cap_bad;
    logic                ack;
    logic                cap_write;
    logic [DIGITS-1:0]   dv_next;

    assign in_pair      = {DigSel, Seg};
    assign s_digsel     = s_q[S_W-1:SEG_W];
    assign s_seg        = s_q[SEG_W-1:0];
    assign pair_changed = (in_pair != s_q);
    assign in_blank     = (DigSel == '0);
    assign sel_onehot   = (s_digsel != '0) &&
                          ((s_digsel & (s_digsel - DIGITS'(1))) == '0);

    seg7_pattern_to_hex u_decode (
        .seg    (s_seg),
        .hit    (hit),
        .nibble (nibble)
    );

    assign capture_en = (state == CAPTURE);
    assign cap_valid  = capture_en && sel_onehot && hit;
    assign cap_bad    = capture_en && sel_onehot && !hit;
    assign ack        = FrameReady && FrameAck;
    // An ack on the capture edge clears the old frame first, so the capture
    // starts the next frame instead of being dropped.
    assign cap_write  = cap_valid && (!FrameReady || ack);
    assign dv_next    = (ack ? '0 : DigitoValido) | s_digsel;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            s_q          <= '0;
            Valor        <= '0;
            DigitoValido <= '0;
            FrameReady   <= 1'b0;
            Erro         <= 1'b0;
            Overrun      <= 1'b0;
`ifdef SEG7_READER_ERR_CNT_EN
            ErrCount     <= '0;
`endif
        end else begin
            // S always tracks the bus; change detection compares against it.
            s_q <= in_pair;

            case (state)
                IDLE: begin
                    if (pair_changed) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (pair_changed) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST)
                            state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // S is refreshed on this edge, so a change arriving during
                    // the capture cycle must be acted on here or it is lost.
                    cnt <= '0;
                    if (!pair_changed)
                        state <= HOLD;
                    else if (in_blank)
                        state <= IDLE;
                    else
                        state <= SETTLE;
                end
                HOLD: begin
                    if (pair_changed) begin
                        cnt   <= '0;
                        state <= in_blank ? IDLE : SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (ack) begin
                FrameReady   <= 1'b0;
                DigitoValido <= '0;
            end

            if (cap_write) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (s_digsel[i])
                        Valor[4*i +: 4] <= nibble;
                end
                DigitoValido <= dv_next;
                FrameReady   <= &dv_next;
            end

            if (cap_valid && FrameReady && !ack)
                Overrun <= 1'b1;

            if (cap_bad) begin
                Erro <= 1'b1;
`ifdef SEG7_READER_ERR_CNT_EN
                if (ErrCount != 8'hFF)
                    ErrCount <= ErrCount + 8'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader
// Directed, table-driven bench for seg7_reader (DIGITS=4, STABLE_CYCLES=3).
// Table entries drive a {DigSel, Seg} pair for a number of cycles and then
// compare every output; hand-written sequences cover reset, capture latency,
// frame ack, ack coinciding with a capture, and reset mid-frame.
module tb_seg7_reader;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001101;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PB = 7'b1100000;
    localparam logic [6:0] PC = 7'b0110001;
    localparam logic [6:0] PD = 7'b1000010;
    localparam logic [6:0] PE = 7'b0110000;
    localparam logic [6:0] PF = 7'b0111000;
    localparam logic [6:0] PX = 7'b1111111;

    typedef struct {
        logic [3:0]  digsel;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] valor;
        logic [3:0]  dv;
        logic        fr;
        logic        erro;
        logic        ovr;
        logic [7:0]  ecnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    logic        Clock = 1'b0;
    logic        Reset;
    logic [0:6]  Seg;
    logic [3:0]  DigSel;
    logic        FrameAck;
    logic [15:0] Valor;
    logic [3:0]  DigitoValido;
    logic        FrameReady;
    logic        Erro;
    logic        Overrun;
`ifdef SEG7_READER_ERR_CNT_EN
    logic [7:0]  ErrCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    seg7_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Seg          (Seg),
        .DigSel       (DigSel),
        .FrameAck     (FrameAck),
        .Valor        (Valor),
        .DigitoValido (DigitoValido),
        .FrameReady   (FrameReady),
        .Erro         (Erro),
        .Overrun      (Overrun)
`ifdef SEG7_READER_ERR_CNT_EN
        ,
        .ErrCount     (ErrCount)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] valor, input logic [3:0] dv,
                             input logic fr, input logic erro, input logic ovr, input logic [7:0] ecnt);
        check({tag, ".Valor"},        Valor,                 valor);
        check({tag, ".DigitoValido"}, {12'd0, DigitoValido}, {12'd0, dv});
        check({tag, ".FrameReady"},   {15'd0, FrameReady},   {15'd0, fr});
        check({tag, ".Erro"},         {15'd0, Erro},         {15'd0, erro});
        check({tag, ".Overrun"},      {15'd0, Overrun},      {15'd0, ovr});
`ifdef SEG7_READER_ERR_CNT_EN
        check({tag, ".ErrCount"},     {8'd0, ErrCount},      {8'd0, ecnt});
`else
        if (ecnt != ecnt) $display("unreachable");
`endif
    endtask

    task automatic drive(input logic [3:0] ds, input logic [6:0] sg);
        DigSel = ds;
        Seg    = sg;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].digsel, vecs[i].seg);
            cycles(vecs[i].hold);
            check_all($sformatf("vec%0d", i), vecs[i].valor, vecs[i].dv,
                      vecs[i].fr, vecs[i].erro, vecs[i].ovr, vecs[i].ecnt);
        end
    endtask

    task automatic pulse_ack();
        FrameAck = 1'b1;
        cycles(1);
        FrameAck = 1'b0;
    endtask

    initial begin
        //             digsel   seg hold  Valor     DV       FR    Erro  Ovr   ErrCount
        // first frame: 1, A, C, F
        vecs[0]  = '{4'b0001, P1, 5, 16'h0001, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{4'b0010, PA, 5, 16'h00A1, 4'b0011, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{4'b0100, PC, 5, 16'h0CA1, 4'b0111, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{4'b1000, PF, 5, 16'hFCA1, 4'b1111, 1'b1, 1'b0, 1'b0, 8'd0};
        // blank pattern on digit 1, glitch, non-one-hot select, second frame
        vecs[4]  = '{4'b0010, PX, 5, 16'hFCA1, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[5]  = '{4'b0100, P3, 5, 16'hF3A1, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[6]  = '{4'b0001, P8, 2, 16'hF3A1, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[7]  = '{4'b1000, P4, 5, 16'h43A1, 4'b1100, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[8]  = '{4'b0011, P0, 5, 16'h43A1, 4'b1100, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[9]  = '{4'b0001, P9, 5, 16'h43A9, 4'b1101, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[10] = '{4'b0010, PB, 5, 16'h43B9, 4'b1111, 1'b1, 1'b1, 1'b0, 8'd1};
        // frame started by the ack+capture of 7, then overrun
        vecs[11] = '{4'b0010, P6, 5, 16'h4367, 4'b0011, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[12] = '{4'b0100, PD, 5, 16'h4D67, 4'b0111, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[13] = '{4'b1000, P0, 5, 16'h0D67, 4'b1111, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[14] = '{4'b0010, PE, 5, 16'h0D67, 4'b1111, 1'b1, 1'b1, 1'b1, 8'd1};
        // partial frame that reset will discard
        vecs[15] = '{4'b0001, P5, 5, 16'h0D65, 4'b0001, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[16] = '{4'b0010, P8, 5, 16'h0D85, 4'b0011, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[17] = '{4'b0100, P2, 5, 16'h0285, 4'b0111, 1'b0, 1'b1, 1'b1, 8'd1};
        // clean frame after reset
        vecs[18] = '{4'b0001, PC, 5, 16'h000C, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd0};

        Reset    = 1'b1;
        FrameAck = 1'b0;
        drive(4'b0000, 7'b0000000);
        cycles(2);
        check_all("reset", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
        Reset = 1'b0;

        // latency: presented before edge k, written at edge k+4
        drive(4'b0001, P2);
        cycles(4);
        check("latency.before", Valor, 16'h0000);
        check("latency.dv_before", {12'd0, DigitoValido}, 16'h0000);
        cycles(1);
        check("latency.after", Valor, 16'h0002);
        check("latency.dv_after", {12'd0, DigitoValido}, 16'h0001);
        cycles(1);

        run_vectors(0, 3);

        pulse_ack();
        check_all("ack1", 16'hFCA1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);

        run_vectors(4, 10);

        // ack on the same edge as the capture of 7 on digit 0
        drive(4'b0001, P7);
        cycles(4);
        check("ackcap.fr_before", {15'd0, FrameReady}, 16'h0001);
        check("ackcap.valor_before", Valor, 16'h43B9);
        pulse_ack();
        check_all("ackcap", 16'h43B7, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd1);

        run_vectors(11, 14);

        pulse_ack();
        check_all("ack3", 16'h0D67, 4'b0000, 1'b0, 1'b1, 1'b1, 8'd1);

        run_vectors(15, 17);

        Reset = 1'b1;
        cycles(1);
        check_all("midreset", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
        Reset = 1'b0;

        run_vectors(18, 18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
